// File: rtl/msk_tof_hpc3_lanes.sv
// Multi-lane masked Toffoli gadget (out = a&b ^ c) using HPC3 share domains.
// Every cross-domain term sits in its own stage-1 register, so the output XOR
// tree only ever sees registered values and no input can glitch through to it.
module msk_tof_hpc3_lanes #(
    parameter int d       = 2,
    parameter int LANES   = 4,
    parameter int OUT_REG = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       swap,
    input  logic [LANES*d-1:0]         ina,
    input  logic [LANES*d-1:0]         inb,
    input  logic [LANES*d-1:0]         inc,
    input  logic [LANES*d*(d-1)-1:0]   rnd,
    input  logic                       rnd_valid,
    output logic [LANES*d-1:0]         out,
    output logic                       out_valid
);
    localparam int NP = d * (d - 1) / 2;  // share pairs i<j per lane
    localparam int RW = d * (d - 1);      // randomness bits per lane
    localparam int XW = LANES * d * (d - 1);

    // Position of pair (i,j) in the ascending (i,j) ordering with i<j; symmetric.
    function automatic int pair_idx(input int i, input int j);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * (2 * d - lo - 1) / 2 + (hi - lo - 1);
    endfunction

    // Slot of the off-diagonal cross term (i,j) of a lane share, j != i.
    function automatic int xslot(input int l, input int i, input int j);
        return (l * d + i) * (d - 1) + ((j < i) ? j : j - 1);
    endfunction

    logic                 accept;
    logic [LANES*d-1:0]   x_all;
    logic [LANES*d-1:0]   y_all;
    logic [LANES*d-1:0]   p_d, p_q;
    logic [XW-1:0]        q_d, q_q;
    logic [XW-1:0]        r_d, r_q;
    logic                 vld1_d, vld1_q;
    logic [LANES*d-1:0]   res;

    assign accept   = in_valid & rnd_valid;
    assign in_ready = rnd_valid;
    assign x_all    = swap ? inb : ina;
    assign y_all    = swap ? ina : inb;

    // Stage-1 next state: load every per-term register on accept, otherwise hold.
    always_comb begin
        p_d    = p_q;
        q_d    = q_q;
        r_d    = r_q;
        vld1_d = accept;
        if (accept) begin
            for (int l = 0; l < LANES; l++) begin
                for (int i = 0; i < d; i++) begin
                    p_d[l*d+i] = (x_all[l*d+i] & y_all[l*d+i]) ^ inc[l*d+i];
                    for (int j = 0; j < d; j++) begin
                        if (j != i) begin
                            q_d[xslot(l, i, j)] = x_all[l*d+i] &
                                (y_all[l*d+j] ^ rnd[l*RW + pair_idx(i, j)]);
                            r_d[xslot(l, i, j)] =
                                (~x_all[l*d+i] & rnd[l*RW + pair_idx(i, j)]) ^
                                rnd[l*RW + NP + pair_idx(i, j)];
                        end
                    end
                end
            end
        end
    end

    // Stage-1 registers: share terms plus the valid bit travelling with them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q    <= '0;
            q_q    <= '0;
            r_q    <= '0;
            vld1_q <= 1'b0;
        end else begin
            p_q    <= p_d;
            q_q    <= q_d;
            r_q    <= r_d;
            vld1_q <= vld1_d;
        end
    end

    // Output XOR tree fed exclusively by stage-1 register outputs.
    always_comb begin
        res = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int i = 0; i < d; i++) begin
                res[l*d+i] = p_q[l*d+i];
                for (int j = 0; j < d; j++) begin
                    if (j != i) begin
                        res[l*d+i] = res[l*d+i] ^ q_q[xslot(l, i, j)] ^ r_q[xslot(l, i, j)];
                    end
                end
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [LANES*d-1:0] out2_d, out2_q;
            logic               vld2_d, vld2_q;

            // Second stage captures a result only when stage 1 holds a live transaction.
            always_comb begin
                out2_d = out2_q;
                vld2_d = vld1_q;
                if (vld1_q) begin
                    out2_d = res;
                end
            end

            // Output register stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out2_q <= '0;
                    vld2_q <= 1'b0;
                end else begin
                    out2_q <= out2_d;
                    vld2_q <= vld2_d;
                end
            end

            assign out       = out2_q;
            assign out_valid = vld2_q;
        end else begin : g_noreg
            // Stage-1 registers hold on idle, so the tree output already keeps the last result.
            assign out       = res;
            assign out_valid = vld1_q;
        end
    endgenerate
endmodule
